// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for fetch, decode and control
package cpu_pkg;

   localparam int BUS_WIDTH_DEF  = 32;
   localparam int ADDR_WIDTH_DEF = 32;

   // Word the fetch stage presents to decode when it has nothing real to give
   localparam logic [BUS_WIDTH_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with push, pop, clear and count
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Clear wins over both push and pop; pop on empty is ignored (bubble upstream)
   assign w_push    = push && !clear;
   assign w_pop     = pop && !clear && (r_count != '0);
   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign empty     = (r_count == '0);

   // Storage array; no reset needed since count gates every read
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, memory issue, prefetch buffer, IF/ID register
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                   BUS_WIDTH  = BUS_WIDTH_DEF,
   parameter int                   ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                   FIFO_DEPTH = 4,
   parameter logic [BUS_WIDTH-1:0] NOP        = BUS_WIDTH'(NOP_INSTR)
) (
   input  logic                          CLK,
   input  logic                          RST,
   output logic                          imem_req,
   output logic [ADDR_WIDTH-1:0]         imem_addr,
   input  logic [BUS_WIDTH-1:0]          imem_rdata,
   input  logic                          stall_d,
   input  logic                          redirect,
   input  logic [ADDR_WIDTH-1:0]         redirect_pc,
   output logic [BUS_WIDTH-1:0]          instr_d,
   output logic [ADDR_WIDTH-1:0]         pc_d,
   output logic                          valid_d,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [31:0]                   cycle_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam int FW = BUS_WIDTH + ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_inflight_addr;
   logic                  r_inflight;
   logic [BUS_WIDTH-1:0]  r_instr_d;
   logic [ADDR_WIDTH-1:0] r_pc_d;
   logic                  r_valid_d;
   logic [31:0]           r_cycle_count;

   logic [CW-1:0]         w_fifo_count;
   logic [OW-1:0]         w_occupancy;
   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic [FW-1:0]         w_head;

   // Reserve a slot for the word in flight so the FIFO can never overflow;
   // a pop in the same cycle is deliberately not credited.
   assign w_occupancy = OW'(w_fifo_count) + OW'(r_inflight);
   assign w_issue     = !RST && !redirect && (w_occupancy < OW'(FIFO_DEPTH));
   assign w_push      = r_inflight && !redirect;
   assign w_pop       = !redirect && !stall_d && !w_empty;

   assign imem_req    = w_issue;
   assign imem_addr   = r_pc;
   assign instr_d     = r_instr_d;
   assign pc_d        = r_pc_d;
   assign valid_d     = r_valid_d;
   assign fifo_count  = w_fifo_count;
   assign cycle_count = r_cycle_count;

   fetch_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .clear     (redirect),
      .push      (w_push),
      .push_data ({imem_rdata, r_inflight_addr}),
      .pop       (w_pop),
      .head_data (w_head),
      .count     (w_fifo_count),
      .empty     (w_empty)
   );

   // PC and in-flight tracking; a redirect kills the in-flight word by not re-arming
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc            <= '0;
         r_inflight      <= 1'b0;
         r_inflight_addr <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_addr <= r_pc;
         end
         if (redirect) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc <= r_pc + ADDR_WIDTH'(1);
         end
      end
   end

   // IF/ID register: redirect bubbles, stall holds, otherwise pop or bubble
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_instr_d <= NOP;
         r_pc_d    <= '0;
         r_valid_d <= 1'b0;
      end else if (redirect) begin
         r_instr_d <= NOP;
         r_valid_d <= 1'b0;
      end else if (!stall_d) begin
         if (!w_empty) begin
            {r_instr_d, r_pc_d} <= w_head;
            r_valid_d           <= 1'b1;
         end else begin
            r_instr_d <= NOP;
            r_valid_d <= 1'b0;
         end
      end
   end

   // Free-running cycle counter since reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cycle_count <= '0;
      end else begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Default-parameter instance
   logic        RST = 1'b1;
   logic        stall_d = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        valid_d;
   logic [2:0]  fifo_count;
   logic [31:0] cycle_count;

   // ADDR_WIDTH=4 instance for wraparound
   logic        b_RST = 1'b1;
   logic        b_stall_d = 1'b0;
   logic        b_redirect = 1'b0;
   logic [3:0]  b_redirect_pc = '0;
   logic [31:0] b_imem_rdata = '0;
   logic        b_imem_req;
   logic [3:0]  b_imem_addr;
   logic [31:0] b_instr_d;
   logic [3:0]  b_pc_d;
   logic        b_valid_d;
   logic [2:0]  b_fifo_count;
   logic [31:0] b_cycle_count;

   fetch_unit u_dut (
      .CLK (CLK), .RST (RST),
      .imem_req (imem_req), .imem_addr (imem_addr), .imem_rdata (imem_rdata),
      .stall_d (stall_d), .redirect (redirect), .redirect_pc (redirect_pc),
      .instr_d (instr_d), .pc_d (pc_d), .valid_d (valid_d),
      .fifo_count (fifo_count), .cycle_count (cycle_count)
   );

   fetch_unit #(.ADDR_WIDTH (4)) u_dut4 (
      .CLK (CLK), .RST (b_RST),
      .imem_req (b_imem_req), .imem_addr (b_imem_addr), .imem_rdata (b_imem_rdata),
      .stall_d (b_stall_d), .redirect (b_redirect), .redirect_pc (b_redirect_pc),
      .instr_d (b_instr_d), .pc_d (b_pc_d), .valid_d (b_valid_d),
      .fifo_count (b_fifo_count), .cycle_count (b_cycle_count)
   );

   // Synchronous memories: word = 0x1000_0000 + address, one cycle after request
   always @(posedge CLK) if (imem_req) imem_rdata <= 32'h1000_0000 + imem_addr;
   always @(posedge CLK) if (b_imem_req) b_imem_rdata <= 32'h1000_0000 + 32'(b_imem_addr);

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned exp_cyc = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RST) exp_cyc = 0;
      else exp_cyc++;
      #1;
   endtask

   task automatic drain_a(input int n);
      logic [31:0] p;
      for (int i = 0; i < n; i++) begin
         tick();
         p = exp_q.pop_front();
         chk("a_valid", valid_d, 1);
         chk("a_pc", pc_d, p);
         chk("a_instr", instr_d, 32'h1000_0000 + p);
      end
   endtask

   task automatic drain_b(input int n);
      logic [31:0] p;
      for (int i = 0; i < n; i++) begin
         tick();
         p = exp_q.pop_front();
         chk("b_valid", b_valid_d, 1);
         chk("b_pc", b_pc_d, p[3:0]);
         chk("b_instr", b_instr_d, 32'h1000_0000 + {28'h0, p[3:0]});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_valid", valid_d, 0);
      chk("rst_instr", instr_d, NOP_INSTR);
      chk("rst_pc", pc_d, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);

      // Release: edge 1 issues 0, edge 2 pushes, edge 3 presents
      RST = 1'b0;
      #1 chk("rel_req", imem_req, 1);
      tick();
      chk("e1_valid", valid_d, 0);
      chk("e1_addr", imem_addr, 1);
      chk("e1_cycle", cycle_count, 1);
      tick();
      chk("e2_valid", valid_d, 0);
      chk("e2_count", fifo_count, 1);
      for (int p = 0; p <= 5; p++) exp_q.push_back(32'(p));
      drain_a(6);
      chk("steady_count", fifo_count, 1);

      // Sustained stall at pc 5
      stall_d = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("stall_pc", pc_d, 5);
         chk("stall_instr", instr_d, 32'h1000_0005);
      end
      chk("stall_full", fifo_count, 4);
      chk("stall_req", imem_req, 0);
      chk("stall_valid", valid_d, 1);
      stall_d = 1'b0;
      for (int p = 6; p <= 13; p++) exp_q.push_back(32'(p));
      drain_a(8);
      chk("cycle_mid", cycle_count, exp_cyc);

      // Redirect while stalled with a full FIFO
      stall_d = 1'b1;
      repeat (6) tick();
      chk("full_before_redir", fifo_count, 4);
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      chk("redir_r_valid", valid_d, 0);
      chk("redir_r_count", fifo_count, 0);
      chk("redir_r_instr", instr_d, NOP_INSTR);
      redirect = 1'b0; stall_d = 1'b0;
      tick(); chk("redir_r1_valid", valid_d, 0);
      tick(); chk("redir_r2_valid", valid_d, 0);
      for (int p = 'h40; p <= 'h42; p++) exp_q.push_back(32'(p));
      drain_a(3);

      // Back-to-back redirects: nothing from 0x10 may surface
      redirect = 1'b1; redirect_pc = 32'h10;
      tick(); chk("bb1_valid", valid_d, 0);
      redirect_pc = 32'h20;
      tick(); chk("bb2_valid", valid_d, 0);
      redirect = 1'b0;
      tick(); chk("bb3_valid", valid_d, 0);
      tick(); chk("bb4_valid", valid_d, 0);
      for (int p = 'h20; p <= 'h22; p++) exp_q.push_back(32'(p));
      drain_a(3);

      // One-edge reset mid-stream
      RST = 1'b1;
      #1 chk("mrst_req", imem_req, 0);
      tick();
      chk("mrst_valid", valid_d, 0);
      chk("mrst_instr", instr_d, NOP_INSTR);
      chk("mrst_pc", pc_d, 0);
      chk("mrst_count", fifo_count, 0);
      chk("mrst_cycle", cycle_count, 0);
      chk("mrst_addr", imem_addr, 0);
      RST = 1'b0;
      tick(); chk("mrst_e1_valid", valid_d, 0);
      tick(); chk("mrst_e2_valid", valid_d, 0);
      for (int p = 0; p <= 2; p++) exp_q.push_back(32'(p));
      drain_a(3);
      chk("cycle_end", cycle_count, exp_cyc);

      // PC wraparound on the 4-bit instance
      tick(); tick();
      b_RST = 1'b0;
      repeat (3) tick();
      b_redirect = 1'b1; b_redirect_pc = 4'd14;
      tick(); chk("wrap_r_valid", b_valid_d, 0);
      b_redirect = 1'b0;
      tick(); tick();
      exp_q.push_back(32'd14); exp_q.push_back(32'd15);
      exp_q.push_back(32'd0);  exp_q.push_back(32'd1);
      drain_b(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
